// File: rtl/arc4_crack.sv
`default_nettype none
// ============================================================================
// Module   : arc4_crack
// Brief    : Brute-force key search. Runs arc4 once per candidate key and stops
//            at the first key whose plaintext is entirely printable ASCII.
// Revision : 1.0 - initial release
// ============================================================================
module arc4_crack #(
  parameter logic [23:0] KEY_LAST = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        arc4_en,
  input  logic        arc4_rdy,
  output logic [23:0] arc4_key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_RUN   = 3'd3,
    S_LEN   = 3'd4,
    S_LENC  = 3'd5,
    S_SCAN  = 3'd6
  } state_t;

  localparam logic [7:0] c_CHAR_LO = 8'h20;
  localparam logic [7:0] c_CHAR_HI = 8'h7E;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic       w_readable;
  logic       w_pass;
  logic       w_fail;
  logic       w_last;

  assign w_readable = (pt_rddata >= c_CHAR_LO) && (pt_rddata <= c_CHAR_HI);
  assign w_last     = (arc4_key == KEY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    arc4_en = 1'b0;
    w_pass  = 1'b0;
    w_fail  = 1'b0;
    rdy     = (r_state == S_IDLE);
    case (r_state)
      S_IDLE:  if (en) w_next = S_START;
      S_START: begin
        // Gating on arc4_rdy keeps the start pulse off a busy arc4.
        if (arc4_rdy) begin
          arc4_en = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY:  if (!arc4_rdy) w_next = S_RUN;
      S_RUN:   if (arc4_rdy) w_next = S_LEN;
      S_LEN:   w_next = S_LENC;
      S_LENC: begin
        if (pt_rddata == 8'd0) w_pass = 1'b1;
        else                   w_next = S_SCAN;
      end
      S_SCAN: begin
        if (!w_readable)         w_fail = 1'b1;
        else if (r_idx == r_len) w_pass = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_pass) w_next = S_IDLE;
    if (w_fail) w_next = w_last ? S_IDLE : S_START;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= 24'd0;
      key_valid <= 1'b0;
      arc4_key  <= 24'd0;
      pt_addr   <= 8'd0;
      r_len     <= 8'd0;
      r_idx     <= 8'd0;
    end else begin
      if ((r_state == S_IDLE) && en) begin
        arc4_key  <= 24'd0;
        key_valid <= 1'b0;
      end
      if ((r_state == S_RUN) && arc4_rdy) pt_addr <= 8'd0;
      // Address 1 is issued while the length is still in flight so the scan
      // runs at one byte per cycle.
      if (r_state == S_LEN) pt_addr <= 8'd1;
      if (r_state == S_LENC) begin
        r_len <= pt_rddata;
        r_idx <= 8'd1;
        if (pt_rddata > 8'd1) pt_addr <= 8'd2;
      end
      if ((r_state == S_SCAN) && w_readable && (r_idx != r_len)) begin
        r_idx <= r_idx + 8'd1;
        if (pt_addr != r_len) pt_addr <= pt_addr + 8'd1;
      end
      if (w_pass) begin
        key       <= arc4_key;
        key_valid <= 1'b1;
      end
      if (w_fail) begin
        if (w_last) key_valid <= 1'b0;
        else        arc4_key  <= arc4_key + 24'd1;
      end
    end
  end

endmodule
`default_nettype wire
